rx_core_gen2: RTL and testbench
===============================

RX_CORE_GEN2 -- requirements
Module: rx_core_gen2

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data bits per frame (legal 5..9).
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set the receive FIFO words (power of 2, >=4).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 AcqSig_i  in  1  one-cycle oversample strobe from the baud generator.
REQ-006 Rx_i  in  1  asynchronous serial line, idle high.
REQ-007 AcqNumPerBit_i  in  4  strobes per bit N; values <4 SHALL act as 4.
REQ-008 p_ParityEnable_i  in  1  1 = parity bit present.
REQ-009 ParityMethod_i  in  1  0 = even, 1 = odd.
REQ-010 p_BigEnd_i  in  1  1 = MSB received first, 0 = LSB first.
REQ-011 StopBits_i  in  1  0 = one stop bit, 1 = two.
REQ-012 n_rd_i  in  1  active-low FIFO pop.
REQ-013 n_OvfClr_i  in  1  active-low clear of the overflow flag.
REQ-014 data_o  out  DATA_W  FIFO head data (show-ahead).
REQ-015 err_o  out  3  FIFO head flags {break, frame, parity}.
REQ-016 p_empty_o / p_full_o  out  1 each  FIFO status.
REQ-017 Level_o  out  clog2(FIFO_DEPTH)+1  words stored.
REQ-018 p_Overflow_o  out  1  sticky: a frame was dropped because the FIFO was full.

Function
REQ-019 Rx_i SHALL pass through a 2-flop synchroniser (Rx_s) before use.
REQ-020 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, RECOVER.
REQ-021 IDLE->START on an AcqSig_i with Rx_s=0. Sample counter cleared. AcqNumPerBit_i, p_ParityEnable_i, ParityMethod_i, p_BigEnd_i and StopBits_i latched; changes mid-frame have no effect.
REQ-022 Each bit SHALL span N strobes, counted 0..N-1. Bit value = majority of samples at counts N/2-1, N/2, N/2+1 (integer division). The bit ends on the strobe at count N-1.
REQ-023 START end, bit=1: false start, return to IDLE, nothing written. Bit=0: go to DATA.
REQ-024 DATA SHALL collect DATA_W bits in the order set by p_BigEnd_i, then go to PARITY if enabled, else STOP.
REQ-025 Parity error SHALL be set when (XOR of data bits, XOR received parity bit, XOR ParityMethod) = 1; with parity disabled the flag SHALL be 0.
REQ-026 STOP SHALL check 1 or 2 stop bits. Frame error SHALL be set if any stop bit is 0. After the first 0 stop bit the remaining stop bits SHALL NOT be checked.
REQ-027 Break SHALL be set when all data bits, the parity bit (if present) and the first stop bit are 0; break implies frame error.
REQ-028 After a frame error the FSM SHALL enter RECOVER and return to IDLE only on an AcqSig_i with Rx_s=1; otherwise the FSM returns directly to IDLE.
REQ-029 On the clk cycle after the strobe ending the last checked stop bit, {err, data} SHALL be written if not full. If full, the word is dropped and p_Overflow_o set.
REQ-030 The FIFO SHALL be show-ahead. A pop when n_rd_i=0 and not empty; pops while empty are ignored.
REQ-031 A write and a pop in the same cycle while full SHALL both take effect, with no overflow. While empty, only the write SHALL take effect.
REQ-032 A written word SHALL appear on data_o/err_o, with p_empty_o=0, one cycle after the write cycle. Level_o and the flags update on the same edge.
REQ-033 p_Overflow_o SHALL stay 1 until n_OvfClr_i=0. A simultaneous new overflow takes priority (flag stays 1).
REQ-034 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-035 With rst=0 at a clk edge the block SHALL enter this state, discarding any partial frame and all FIFO contents:
- FSM in IDLE, synchroniser at 1.
- data_o=0, err_o=0, p_empty_o=1, p_full_o=0, Level_o=0, p_Overflow_o=0.

Verification
REQ-036 N=8, 8N1 LSB-first, byte 0xA5 -> data_o=0xA5, err_o=000, Level_o=1.
REQ-037 Even parity, 0x03 sent with parity bit 1 -> data_o=0x03, err_o=001. Odd parity, same frame -> err_o=000.
REQ-038 Line held low 12 bit-times (8N1) -> one word data_o=0x00, err_o=110. No second word until Rx returns high and a new start arrives.
REQ-039 Start pulse of 2 strobes at N=8 -> no write, FSM back in IDLE, Level_o=0.
REQ-040 FIFO_DEPTH=4, 5 frames with no reads -> p_full_o=1, p_Overflow_o=1, first 4 words intact. n_OvfClr_i pulse clears the flag.
REQ-041 rst=0 in the middle of the DATA state -> all outputs at reset values next cycle; the following clean frame is received correctly.

Source files
------------

// File: rtl/rx_core_gen2.sv
// rx_core_gen2: oversampling serial receiver with majority-vote bit sampling and a show-ahead receive FIFO
module rx_core_gen2 #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          AcqSig_i,
  input  logic                          Rx_i,
  input  logic [3:0]                    AcqNumPerBit_i,
  input  logic                          p_ParityEnable_i,
  input  logic                          ParityMethod_i,
  input  logic                          p_BigEnd_i,
  input  logic                          StopBits_i,
  input  logic                          n_rd_i,
  input  logic                          n_OvfClr_i,
  output logic [DATA_W-1:0]             data_o,
  output logic [2:0]                    err_o,
  output logic                          p_empty_o,
  output logic                          p_full_o,
  output logic [$clog2(FIFO_DEPTH):0]   Level_o,
  output logic                          p_Overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
  state_t state, nxt;
  logic rx_m, rx_s;
  logic [3:0] cnt, n_l, half, bit_idx;
  logic pe_l, pm_l, be_l, sb_l;
  logic [1:0] votes, vsum;
  logic [DATA_W-1:0] sh;
  logic stop_idx, par, zero;
  logic samp, bit_end, bit_v, frame_done, wr;
  logic [DATA_W+2:0] wr_word;
  logic [DATA_W+2:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] level;
  logic full, empty, pop, push, ovf_set;
  assign half = n_l >> 1;
  assign samp = cnt == half - 4'd1 || cnt == half || cnt == half + 4'd1;
  assign vsum = votes + {1'b0, samp & rx_s};
  assign bit_v = vsum[1];
  assign bit_end = AcqSig_i && cnt == n_l - 4'd1;
  assign frame_done = state == STOP && bit_end && (!bit_v || stop_idx == sb_l);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (AcqSig_i && !rx_s) ? START : IDLE;
      START:   nxt = bit_end ? (bit_v ? IDLE : DATA) : START;
      DATA:    nxt = (bit_end && bit_idx == 4'(DATA_W-1)) ? (pe_l ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      STOP:    nxt = !bit_end ? STOP : !bit_v ? RECOVER : (stop_idx == sb_l) ? IDLE : STOP;
      RECOVER: nxt = (AcqSig_i && rx_s) ? IDLE : RECOVER;
      default: nxt = IDLE;
    endcase
  end
  // The detecting strobe is count 0 of the start bit, so the counter resumes at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt <= '0;
      votes <= '0;
      bit_idx <= '0;
      stop_idx <= 1'b0;
      par <= 1'b0;
      zero <= 1'b1;
      sh <= '0;
      n_l <= 4'd4;
      {pe_l, pm_l, be_l, sb_l} <= '0;
      wr <= 1'b0;
      wr_word <= '0;
    end else begin
      rx_m <= Rx_i;
      rx_s <= rx_m;
      state <= nxt;
      wr <= frame_done;
      if (frame_done) wr_word <= {zero & !bit_v & !stop_idx, !bit_v, pe_l & par, sh};
      if (state == IDLE) begin
        cnt <= '0;
        votes <= '0;
        bit_idx <= '0;
        stop_idx <= 1'b0;
        par <= 1'b0;
        zero <= 1'b1;
        if (AcqSig_i && !rx_s) begin
          cnt <= 4'd1;
          n_l <= AcqNumPerBit_i < 4'd4 ? 4'd4 : AcqNumPerBit_i;
          {pe_l, pm_l, be_l, sb_l} <= {p_ParityEnable_i, ParityMethod_i, p_BigEnd_i, StopBits_i};
        end
      end else if (AcqSig_i) begin
        cnt <= bit_end ? 4'd0 : cnt + 4'd1;
        votes <= bit_end ? 2'd0 : vsum;
        if (bit_end && state == DATA) begin
          sh <= be_l ? {sh[DATA_W-2:0], bit_v} : {bit_v, sh[DATA_W-1:1]};
          par <= par ^ bit_v;
          zero <= zero & !bit_v;
          bit_idx <= bit_idx + 4'd1;
        end
        if (bit_end && state == PARITY) begin
          par <= par ^ bit_v ^ pm_l;
          zero <= zero & !bit_v;
        end
        if (bit_end && state == STOP) stop_idx <= 1'b1;
      end
    end
  end
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign empty = level == '0;
  assign pop = !n_rd_i && !empty;
  assign push = wr && (!full || pop);
  assign ovf_set = wr && full && !pop;
  always_ff @(posedge clk) if (push) mem[wp] <= wr_word;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      p_Overflow_o <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      p_Overflow_o <= ovf_set | (p_Overflow_o & n_OvfClr_i);
    end
  end
  assign data_o = empty ? '0 : mem[rp][DATA_W-1:0];
  assign err_o = empty ? '0 : mem[rp][DATA_W+2:DATA_W];
  assign p_empty_o = empty;
  assign p_full_o = full;
  assign Level_o = level;
endmodule

// File: tb/tb_rx_core_gen2.sv
// tb_rx_core_gen2: drives serial frames strobe by strobe and checks FIFO output against hand tables and a frame model
module tb_rx_core_gen2;
  logic clk = 1'b0, rst = 1'b0, AcqSig_i = 1'b0, Rx_i = 1'b1;
  logic [3:0] AcqNumPerBit_i = 4'd8;
  logic p_ParityEnable_i = 1'b0, ParityMethod_i = 1'b0, p_BigEnd_i = 1'b0, StopBits_i = 1'b0;
  logic n_rd_i = 1'b1, n_OvfClr_i = 1'b1;
  logic [7:0] data_o;
  logic [2:0] err_o;
  logic p_empty_o, p_full_o, p_Overflow_o;
  logic [2:0] Level_o;
  int checks = 0, failures = 0;

  rx_core_gen2 #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .AcqSig_i(AcqSig_i), .Rx_i(Rx_i), .AcqNumPerBit_i(AcqNumPerBit_i),
    .p_ParityEnable_i(p_ParityEnable_i), .ParityMethod_i(ParityMethod_i), .p_BigEnd_i(p_BigEnd_i),
    .StopBits_i(StopBits_i), .n_rd_i(n_rd_i), .n_OvfClr_i(n_OvfClr_i), .data_o(data_o), .err_o(err_o),
    .p_empty_o(p_empty_o), .p_full_o(p_full_o), .Level_o(Level_o), .p_Overflow_o(p_Overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] line;
    logic [3:0] n;
    logic pe, pm, be, sb, pbit, s0, s1;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Synchroniser needs two edges, so the strobe lands on the third edge after Rx changes.
  task automatic send_bit(input logic v, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      Rx_i = v;
      repeat (2) @(negedge clk);
      AcqSig_i = 1'b1;
      @(negedge clk);
      AcqSig_i = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] line, input logic [3:0] n, input logic pe, pm, be, sb,
                            input logic pbit, s0, s1, input logic pop_end, input logic scramble);
    int ne;
    ne = n < 4 ? 4 : int'(n);
    AcqNumPerBit_i = n;
    p_ParityEnable_i = pe;
    ParityMethod_i = pm;
    p_BigEnd_i = be;
    StopBits_i = sb;
    send_bit(1'b0, ne);
    if (scramble) begin
      AcqNumPerBit_i = 4'($urandom);
      {p_ParityEnable_i, ParityMethod_i, p_BigEnd_i, StopBits_i} = 4'($urandom);
    end
    for (int i = 0; i < 8; i++) send_bit(line[i], ne);
    if (pe) send_bit(pbit, ne);
    send_bit(s0, ne);
    if (sb) send_bit(s1, ne);
    if (pop_end) begin
      n_rd_i = 1'b0;
      @(negedge clk);
      n_rd_i = 1'b1;
    end
    send_bit(1'b1, 2);
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_one();
    n_rd_i = 1'b0;
    @(negedge clk);
    n_rd_i = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [10:0] model(input logic [7:0] line, input logic pe, pm, be, sb, pbit, s0, s1);
    logic [7:0] d;
    logic p, f, b;
    for (int i = 0; i < 8; i++) d[i] = be ? line[7-i] : line[i];
    p = pe & (^line ^ pbit ^ pm);
    f = !s0 || (sb && !s1);
    b = line == 8'h00 && (!pe || !pbit) && !s0;
    return {b, f, p, d};
  endfunction

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_data"}, data_o, 0);
    chk({nm, "_err"}, err_o, 0);
    chk({nm, "_empty"}, p_empty_o, 1);
    chk({nm, "_full"}, p_full_o, 0);
    chk({nm, "_level"}, Level_o, 0);
    chk({nm, "_ovf"}, p_Overflow_o, 0);
  endtask

  initial begin
    logic [7:0] line, v;
    logic [3:0] n;
    logic pe, pm, be, sb, pbit, s0, s1;
    logic [10:0] exp;
    tbl[0]  = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h0A5};
    tbl[1]  = '{8'h03, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h103};
    tbl[2]  = '{8'h03, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 11'h003};
    tbl[3]  = '{8'h01, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'h080};
    tbl[4]  = '{8'h55, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h255};
    tbl[5]  = '{8'h3C, 4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h23C};
    tbl[6]  = '{8'h7E, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'h07E};
    tbl[7]  = '{8'hC3, 4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h0C3};
    tbl[8]  = '{8'h00, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h600};
    tbl[9]  = '{8'h00, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h700};
    tbl[10] = '{8'h01, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h001};
    tbl[11] = '{8'hF0, 4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 11'h00F};
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    send_bit(1'b1, 4);
    for (int i = 0; i < 12; i++) begin
      send_frame(tbl[i].line, tbl[i].n, tbl[i].pe, tbl[i].pm, tbl[i].be, tbl[i].sb,
                 tbl[i].pbit, tbl[i].s0, tbl[i].s1, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_word", i), {err_o, data_o}, tbl[i].exp);
      chk($sformatf("tbl%0d_level", i), Level_o, 1);
      pop_one();
      chk($sformatf("tbl%0d_empty", i), p_empty_o, 1);
    end
    // Line stuck low: one break word, then nothing until a fresh start bit.
    AcqNumPerBit_i = 4'd8;
    {p_ParityEnable_i, p_BigEnd_i, StopBits_i} = 3'b000;
    send_bit(1'b0, 96);
    send_bit(1'b1, 16);
    chk("break_word", {err_o, data_o}, 11'h600);
    chk("break_level", Level_o, 1);
    send_bit(1'b1, 8);
    chk("break_no_second", Level_o, 1);
    pop_one();
    // Two-strobe glitch is a false start.
    send_bit(1'b0, 2);
    send_bit(1'b1, 14);
    chk("false_start_level", Level_o, 0);
    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("after_false_start", {err_o, data_o}, 11'h05A);
    pop_one();
    // Overflow with five frames and no reads.
    for (int k = 0; k < 5; k++) begin
      v = 8'(17 * (k + 1));
      send_frame(v, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_full", p_full_o, 1);
    chk("ovf_flag", p_Overflow_o, 1);
    chk("ovf_level", Level_o, 4);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", p_Overflow_o, 1);
    n_OvfClr_i = 1'b0;
    @(negedge clk);
    n_OvfClr_i = 1'b1;
    chk("ovf_cleared", p_Overflow_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_word%0d", k), data_o, 8'(17 * (k + 1)));
      pop_one();
    end
    chk("ovf_drained", p_empty_o, 1);
    // Write and pop in the same cycle while full.
    for (int k = 0; k < 5; k++)
      send_frame(8'h21 + 8'(k), 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, k == 4, 1'b0);
    chk("wrpop_level", Level_o, 4);
    chk("wrpop_ovf", p_Overflow_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrpop_word%0d", k), data_o, 8'h22 + 8'(k));
      pop_one();
    end
    chk("wrpop_empty", p_empty_o, 1);
    // Reset in the middle of DATA discards frame and FIFO contents.
    send_frame(8'h99, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b0, 12);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_reset_outputs("midreset");
    send_bit(1'b1, 8);
    send_frame(8'hE7, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("midreset_next", {err_o, data_o}, 11'h0E7);
    chk("midreset_level", Level_o, 1);
    pop_one();
    // Random frames against the model; config pins scrambled mid-frame.
    for (int i = 0; i < 40; i++) begin
      line = 8'($urandom);
      n = 4'($urandom_range(0, 15));
      {pe, pm, be, sb, pbit} = 5'($urandom);
      s0 = $urandom_range(0, 7) != 0;
      s1 = $urandom_range(0, 7) != 0;
      if (i % 10 == 0) begin
        line = 8'h00;
        s0 = 1'b0;
        pbit = 1'b0;
      end
      exp = model(line, pe, pm, be, sb, pbit, s0, s1);
      send_frame(line, n, pe, pm, be, sb, pbit, s0, s1, 1'b0, 1'b1);
      chk($sformatf("rnd%0d_word", i), {err_o, data_o}, exp);
      chk($sformatf("rnd%0d_level", i), Level_o, 1);
      pop_one();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
